// File: rtl/iob_split_reg.sv
// ----------------------------------------------------------------------------
// iob_split_reg
//
// Registered native-bus splitter. One master request is routed to one of
// N_SLAVES slaves. The slave is chosen by the select field
// m_addr[P_SLAVES -: SEL_W]. Address, write data and strobes are captured
// into a request register. The response comes back from the slave named by
// the captured select. A select with no matching slave completes with
// ERR_DATA and sets a sticky error flag. Only one transaction is in flight
// at a time. This breaks the combinational valid/ready path between master
// and slaves.
//
// Optional feature (compile-time macro):
//   IOB_SPLIT_TIMEOUT_EN - a slave that stays silent for TIMEOUT BUSY cycles
//                          is abandoned and the master gets an error response.
//                          Without the macro, BUSY waits indefinitely.
//
// Ports
//   clk      in   1                  clock
//   rst      in   1                  synchronous reset, active high
//   m_valid  in   1                  master request, held until m_ready
//   m_addr   in   ADDR_W             master address
//   m_wdata  in   DATA_W             master write data
//   m_wstrb  in   DATA_W/8           byte strobes, 0 = read
//   m_rdata  out  DATA_W             read data, valid while m_ready=1
//   m_ready  out  1                  one-cycle completion pulse
//   s_valid  out  N_SLAVES           one-hot slave request
//   s_addr   out  N_SLAVES*ADDR_W    captured address on every slot
//   s_wdata  out  N_SLAVES*DATA_W    captured write data on every slot
//   s_wstrb  out  N_SLAVES*DATA_W/8  captured strobes on every slot
//   s_rdata  in   N_SLAVES*DATA_W    slave read data, slot i = slave i
//   s_ready  in   N_SLAVES           slave completion
//   err_o    out  1                  sticky error flag
//   err_clr  in   1                  clears err_o (a same-cycle set wins)
// ----------------------------------------------------------------------------
module iob_split_reg #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned N_SLAVES = 2,
  parameter int unsigned P_SLAVES = ADDR_W - 1,
  parameter logic [31:0] ERR_DATA = 32'hDEADC0DE,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           m_valid,
  input  logic [ADDR_W-1:0]              m_addr,
  input  logic [DATA_W-1:0]              m_wdata,
  input  logic [DATA_W/8-1:0]            m_wstrb,
  output logic [DATA_W-1:0]              m_rdata,
  output logic                           m_ready,
  output logic [N_SLAVES-1:0]            s_valid,
  output logic [N_SLAVES*ADDR_W-1:0]     s_addr,
  output logic [N_SLAVES*DATA_W-1:0]     s_wdata,
  output logic [N_SLAVES*DATA_W/8-1:0]   s_wstrb,
  input  logic [N_SLAVES*DATA_W-1:0]     s_rdata,
  input  logic [N_SLAVES-1:0]            s_ready,
  output logic                           err_o,
  input  logic                           err_clr
);

  localparam int unsigned SEL_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;

  // The select field is one bit wider here so that a power-of-two
  // N_SLAVES still fits and the range check stays a plain compare.
  localparam logic [SEL_W:0]      N_SLV      = (SEL_W + 1)'(N_SLAVES);
  localparam logic [DATA_W-1:0]   ERR_DATA_W = DATA_W'(ERR_DATA);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_ERR,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [SEL_W-1:0]    r_sel;
  logic [N_SLAVES-1:0] r_s_valid;
  logic [DATA_W-1:0]   r_m_rdata;
  logic                r_m_ready;
  logic                r_err;

  logic [SEL_W-1:0]    w_sel;
  logic                w_sel_mapped;
  logic                w_sel_ready;
  logic [DATA_W-1:0]   w_sel_rdata;

`ifdef IOB_SPLIT_TIMEOUT_EN
  localparam int unsigned         CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]               r_cnt;
`endif

  assign w_sel        = m_addr[P_SLAVES -: SEL_W];
  assign w_sel_mapped = ({1'b0, w_sel} < N_SLV);

  // Response mux keyed on the captured select. Ready bits and data of
  // the other slaves never reach the FSM.
  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_sel_ready = s_ready[i];
        w_sel_rdata = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only. All of them
  // then update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_sel     <= '0;
      r_s_valid <= '0;
      r_m_rdata <= '0;
      r_m_ready <= 1'b0;
      r_err     <= 1'b0;
`ifdef IOB_SPLIT_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_m_ready <= 1'b0;
      // Clear first. A set later in this block overrides it, so an
      // error in the same cycle as err_clr is not lost.
      if (err_clr) begin
        r_err <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (m_valid) begin
            r_addr  <= m_addr;
            r_wdata <= m_wdata;
            r_wstrb <= m_wstrb;
            r_sel   <= w_sel;
            if (w_sel_mapped) begin
              r_s_valid <= N_SLAVES'(1) << w_sel;
              r_state   <= S_BUSY;
`ifdef IOB_SPLIT_TIMEOUT_EN
              r_cnt     <= '0;
`endif
            end else begin
              r_state <= S_ERR;
            end
          end
        end

        S_BUSY: begin
          if (w_sel_ready) begin
            r_m_rdata <= w_sel_rdata;
            r_s_valid <= '0;
            r_m_ready <= 1'b1;
            r_state   <= S_RESP;
          end
`ifdef IOB_SPLIT_TIMEOUT_EN
          else if (r_cnt == CNT_MAX) begin
            // The slave has had TIMEOUT cycles. Abandon it.
            r_m_rdata <= ERR_DATA_W;
            r_s_valid <= '0;
            r_m_ready <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end

        S_ERR: begin
          r_m_rdata <= ERR_DATA_W;
          r_m_ready <= 1'b1;
          r_err     <= 1'b1;
          r_state   <= S_RESP;
        end

        S_RESP: begin
          // m_ready was raised on entry. The default above drops it now.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_rdata = r_m_rdata;
  assign m_ready = r_m_ready;
  assign s_valid = r_s_valid;
  assign s_addr  = {N_SLAVES{r_addr}};
  assign s_wdata = {N_SLAVES{r_wdata}};
  assign s_wstrb = {N_SLAVES{r_wstrb}};
  assign err_o   = r_err;

endmodule

// File: tb/tb_iob_split_reg.sv
// ----------------------------------------------------------------------------
// tb_iob_split_reg
//
// Drives two splitters from one clock:
//   u_dut4 - 4 slaves: every select is mapped. Used for the main traffic,
//            back-to-back, reset and hang/timeout sequences.
//   u_dut3 - 3 slaves: select 3 is unmapped. Used for the error path and
//            the err_o set/clear rules.
// Inputs are driven on the falling edge and outputs are sampled on it.
// Cycle T is the cycle whose rising edge accepts a request.
// ----------------------------------------------------------------------------
module tb_iob_split_reg;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-slave instance
  logic          m_valid;
  logic [31:0]   m_addr, m_wdata, m_rdata;
  logic [3:0]    m_wstrb;
  logic          m_ready;
  logic [3:0]    s_valid, s_ready;
  logic [127:0]  s_addr, s_wdata, s_rdata;
  logic [15:0]   s_wstrb;
  logic          err_o, err_clr;

  // 3-slave instance
  logic          m3_valid;
  logic [31:0]   m3_addr, m3_wdata, m3_rdata;
  logic [3:0]    m3_wstrb;
  logic          m3_ready;
  logic [2:0]    s3_valid, s3_ready;
  logic [95:0]   s3_addr, s3_wdata, s3_rdata;
  logic [11:0]   s3_wstrb;
  logic          err3_o, err3_clr;

  iob_split_reg #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(4), .P_SLAVES(31),
                  .ERR_DATA(32'hDEADC0DE), .TIMEOUT(TMO)) u_dut4 (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .err_o(err_o), .err_clr(err_clr)
  );

  iob_split_reg #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(3), .P_SLAVES(31),
                  .ERR_DATA(32'hDEADC0DE), .TIMEOUT(TMO)) u_dut3 (
    .clk(clk), .rst(rst),
    .m_valid(m3_valid), .m_addr(m3_addr), .m_wdata(m3_wdata), .m_wstrb(m3_wstrb),
    .m_rdata(m3_rdata), .m_ready(m3_ready),
    .s_valid(s3_valid), .s_addr(s3_addr), .s_wdata(s3_wdata), .s_wstrb(s3_wstrb),
    .s_rdata(s3_rdata), .s_ready(s3_ready),
    .err_o(err3_o), .err_clr(err3_clr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One transaction record: stimulus plus what the master must observe.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          dly;      // slave raises s_ready in cycle T+dly
    logic [31:0] rdata;    // what the slave returns
    logic [3:0]  exp_sv;   // required one-hot s_valid while waiting
    int          exp_lat;  // required m_ready cycle relative to T
    logic [31:0] exp_rd;   // required m_rdata during m_ready
  } vec_t;

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int dly,
                              input logic [31:0] rdata, input logic [3:0] exp_sv,
                              input int exp_lat, input logic [31:0] exp_rd);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.dly = dly; v.rdata = rdata;
    v.exp_sv = exp_sv; v.exp_lat = exp_lat; v.exp_rd = exp_rd;
    return v;
  endfunction

  // Reference model for 4 slaves: the top two address bits name the slave,
  // and the answer arrives one cycle after the slave's ready.
  function automatic vec_t model4(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] wstrb, input int dly,
                                  input logic [31:0] rdata);
    int slave;
    slave = int'(addr >> 30);
    return mk(addr, wdata, wstrb, dly, rdata, 4'(1 << slave), dly + 1, rdata);
  endfunction

  logic [31:0] last_rd4 = 32'h0;

  task automatic run4(input string tag, input vec_t v, output int t_done);
    int sel, got, bad;
    logic [3:0] sv_exp;
    sel = 0;
    for (int i = 0; i < 4; i++) if (v.exp_sv[i]) sel = i;
    @(negedge clk);
    check({tag, ".idle_hold"}, {m_ready, m_rdata}, {1'b0, last_rd4});
    m_valid = 1'b1; m_addr = v.addr; m_wdata = v.wdata; m_wstrb = v.wstrb;
    got = 0; bad = 0;
    for (int c = 1; c <= v.dly + 20; c++) begin
      @(negedge clk);
      if (m_ready) begin
        got = c;
        break;
      end
      sv_exp = (c <= v.dly) ? v.exp_sv : 4'b0000;
      if (s_valid !== sv_exp || s_addr !== {4{v.addr}} || s_wdata !== {4{v.wdata}} ||
          s_wstrb !== {4{v.wstrb}}) bad++;
      if (c == 1) begin
        check({tag, ".s_valid"}, s_valid, v.exp_sv);
        check({tag, ".s_addr"}, s_addr, {4{v.addr}});
        check({tag, ".s_wdata_wstrb"}, {s_wdata, s_wstrb}, {{4{v.wdata}}, {4{v.wstrb}}});
      end
      // Non-selected slaves chatter on ready and data; they must be ignored.
      s_ready = 4'($urandom()) & ~v.exp_sv;
      s_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (c == v.dly) begin
        s_ready = s_ready | v.exp_sv;
        s_rdata[sel*32 +: 32] = v.rdata;
      end
    end
    t_done = cyc;
    check({tag, ".latency"}, 128'(got), 128'(v.exp_lat));
    check({tag, ".rdata"}, m_rdata, v.exp_rd);
    check({tag, ".busy_cycles_bad"}, 128'(bad), 128'(0));
    check({tag, ".s_valid_resp"}, s_valid, 4'b0000);
    m_valid = 1'b0;
    s_ready = 4'b0000;
    last_rd4 = v.exp_rd;
  endtask

  // Unmapped request on the 3-slave instance: error response at T+2.
  task automatic err3_txn(input string tag);
    @(negedge clk);
    m3_valid = 1'b1; m3_addr = 32'hC000_0000; m3_wdata = 32'h1111_2222; m3_wstrb = 4'hF;
    @(negedge clk);
    check({tag, ".t1"}, {m3_ready, s3_valid}, {1'b0, 3'b000});
    @(negedge clk);
    check({tag, ".t2"}, {m3_ready, m3_rdata, err3_o, s3_valid},
          {1'b1, 32'hDEADC0DE, 1'b1, 3'b000});
    m3_valid = 1'b0;
  endtask

  vec_t tbl[6];
  int   t_done[6];
  int   td, got, hi, extra;
  vec_t v;

  initial begin
    rst = 1'b1;
    m_valid = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0; s_rdata = '0; s_ready = 0; err_clr = 0;
    m3_valid = 0; m3_addr = 0; m3_wdata = 0; m3_wstrb = 0; s3_rdata = '0; s3_ready = 0; err3_clr = 0;

    tbl[0] = mk(32'h4000_0010, 32'hDEADBEEF, 4'hF, 1, 32'h0BAD_F00D, 4'b0010, 2, 32'h0BAD_F00D);
    tbl[1] = mk(32'h8000_0004, 32'h0,        4'h0, 5, 32'h1234_5678, 4'b0100, 6, 32'h1234_5678);
    tbl[2] = mk(32'h0000_0008, 32'h0,        4'h0, 1, 32'hAAAA_0000, 4'b0001, 2, 32'hAAAA_0000);
    tbl[3] = mk(32'h4000_000C, 32'h0,        4'h0, 1, 32'h0000_BBBB, 4'b0010, 2, 32'h0000_BBBB);
    tbl[4] = mk(32'hC000_0FFC, 32'h5A5A5A5A, 4'h5, 3, 32'hCAFE_0001, 4'b1000, 4, 32'hCAFE_0001);
    tbl[5] = mk(32'h3FFF_FFFC, 32'h0,        4'h0, 2, 32'h0102_0304, 4'b0001, 3, 32'h0102_0304);

    repeat (3) @(negedge clk);
    check("rst.dut4_ctl", {m_ready, m_rdata, s_valid, err_o}, '0);
    check("rst.dut4_fields", {s_addr, s_wstrb}, '0);
    check("rst.dut4_wdata", s_wdata, '0);
    check("rst.dut3_ctl", {m3_ready, m3_rdata, s3_valid, err3_o}, '0);
    rst = 1'b0;

    // Directed table; entries 2 and 3 run back to back.
    for (int i = 0; i < 6; i++) run4($sformatf("vec%0d", i), tbl[i], t_done[i]);
    check("b2b.gap", 128'(t_done[3] - t_done[2]), 128'(3));

    // Randomised traffic against the model.
    for (int i = 0; i < 30; i++) begin
      v = model4($urandom(), $urandom(), 4'($urandom()), int'($urandom_range(1, 6)), $urandom());
      run4($sformatf("rnd%0d", i), v, td);
    end

`ifndef IOB_SPLIT_TIMEOUT_EN
    // Without the timeout a silent slave is waited on for as long as needed.
    v = model4(32'h0000_0040, 32'h0, 4'h0, 40, 32'h7777_8888);
    run4("hang", v, td);
`endif
    check("dut4.err_clear", err_o, 1'b0);

    // Reset in cycle T+3 of a pending read.
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h8000_0020; m_wstrb = 4'h0; s_ready = 4'b0000;
    repeat (3) @(negedge clk);
    check("rstmid.busy", s_valid, 4'b0100);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid.after", {s_valid, m_ready, m_rdata}, '0);
    rst = 1'b0; m_valid = 1'b0;
    last_rd4 = 32'h0;
    run4("rstmid.next", mk(32'hC000_0100, 32'h0, 4'h0, 2, 32'h3333_4444, 4'b1000, 3, 32'h3333_4444), td);

    // Error path on the 3-slave instance.
    err3_txn("err");
    @(negedge clk);
    check("err.pulse_hold", {m3_ready, m3_rdata, err3_o}, {1'b0, 32'hDEADC0DE, 1'b1});
    err3_clr = 1'b1;
    @(negedge clk);
    err3_clr = 1'b0;
    check("err.clr", err3_o, 1'b0);
    s3_ready = 3'b111;                       // stray ready while idle
    repeat (2) @(negedge clk);
    check("err.late_ready", {m3_ready, s3_valid}, {1'b0, 3'b000});
    s3_ready = 3'b000;
    err3_clr = 1'b1;                         // set beats a simultaneous clear
    err3_txn("errprio");
    @(negedge clk);
    check("errprio.cleared", err3_o, 1'b0);
    err3_clr = 1'b0;

`ifdef IOB_SPLIT_TIMEOUT_EN
    // Slave 0 never answers: s_valid for TMO cycles, then an error response.
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h0000_0100; m_wstrb = 4'h0;
    got = 0; hi = 0; extra = 0;
    for (int c = 1; c <= TMO + 12; c++) begin
      @(negedge clk);
      if (s_valid === 4'b0001) hi++;
      if (m_ready) begin
        if (got == 0) begin
          got = c;
          check("tmo.rdata_err", {m_rdata, err_o}, {32'hDEADC0DE, 1'b1});
          m_valid = 1'b0;
        end else extra++;
      end
      s_ready = (got != 0) ? 4'b1111 : (4'($urandom()) & 4'b1110);
    end
    s_ready = 4'b0000;
    check("tmo.svalid_cycles", 128'(hi), 128'(TMO));
    check("tmo.latency", 128'(got), 128'(TMO + 1));
    check("tmo.late_ready", {128'(extra), s_valid}, '0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
